// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and width helpers for the FIFO controller
package fifo_pkg;

   localparam int DEF_DEPTH     = 8;
   localparam int DEF_AE_THRESH = 2;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Occupancy spans 0..DEPTH inclusive, so it needs one bit beyond the address.
   function automatic int count_width(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping FIFO pointer with increment and synchronous clear
module fifo_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - single-clock FIFO controller sequencing a dual-port RAM
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AW        = clog2(DEPTH),
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = DEF_AE_THRESH
) (
   input  logic          clk,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          wr_en_i,
   input  logic          rd_en_i,
   input  logic          clr_err_i,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_waddr_o,
   output logic          mem_re_o,
   output logic [AW-1:0] mem_raddr_o,
   output logic          rd_valid_o,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          almost_full_o,
   output logic          almost_empty_o,
   output logic          ovf_o,
   output logic          udf_o
);

   localparam int CW = count_width(DEPTH);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [CW-1:0] wr_ptr;
   logic [CW-1:0] rd_ptr;
   logic [CW-1:0] count_next;
   logic          push_ok;
   logic          pop_ok;
   logic          ptr_clr;
   logic          ovf_set;
   logic          udf_set;

   // Flags come from registered state only, so a full FIFO never accepts a
   // push that a simultaneous pop would have made room for (and vice versa).
   assign push_ok = wr_en_i & ~full_o  & ~flush_i & ~rst_i;
   assign pop_ok  = rd_en_i & ~empty_o & ~flush_i & ~rst_i;
   assign ptr_clr = rst_i | flush_i;

   assign ovf_set = wr_en_i & full_o  & ~flush_i;
   assign udf_set = rd_en_i & empty_o & ~flush_i;

   fifo_ptr #(.W(CW)) u_wr_ptr (
      .clk (clk),
      .clr (ptr_clr),
      .inc (push_ok),
      .ptr (wr_ptr)
   );

   fifo_ptr #(.W(CW)) u_rd_ptr (
      .clk (clk),
      .clr (ptr_clr),
      .inc (pop_ok),
      .ptr (rd_ptr)
   );

   assign mem_we_o    = push_ok;
   assign mem_waddr_o = wr_ptr[AW-1:0];
   assign mem_re_o    = pop_ok;
   assign mem_raddr_o = rd_ptr[AW-1:0];

   always_comb begin
      count_next = count_o;
      if (push_ok && !pop_ok) begin
         count_next = count_o + CW'(1);
      end else if (pop_ok && !push_ok) begin
         count_next = count_o - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_i || flush_i) begin
         count_o        <= '0;
         full_o         <= 1'b0;
         empty_o        <= 1'b1;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
         rd_valid_o     <= 1'b0;
      end else begin
         count_o        <= count_next;
         full_o         <= (count_next == DEPTH_C);
         empty_o        <= (count_next == '0);
         almost_full_o  <= (count_next >= AF_C);
         almost_empty_o <= (count_next <= AE_C);
         rd_valid_o     <= pop_ok;
      end
   end

   // Sticky error flags survive a flush; a new error wins over a clear.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         ovf_o <= 1'b0;
         udf_o <= 1'b0;
      end else begin
         if (ovf_set) begin
            ovf_o <= 1'b1;
         end else if (clr_err_i) begin
            ovf_o <= 1'b0;
         end
         if (udf_set) begin
            udf_o <= 1'b1;
         end else if (clr_err_i) begin
            udf_o <= 1'b0;
         end
      end
   end

   // Pointer distance (with the wrap bit) must always equal the occupancy.
   always_ff @(posedge clk) begin
      if (!rst_i) begin
         assert (count_o == wr_ptr - rd_ptr);
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl
module tb_fifo_ctrl;

   logic       clk;
   logic       rst_i;
   logic       flush_i;
   logic       wr_en_i;
   logic       rd_en_i;
   logic       clr_err_i;
   logic       mem_we_o;
   logic [2:0] mem_waddr_o;
   logic       mem_re_o;
   logic [2:0] mem_raddr_o;
   logic       rd_valid_o;
   logic [3:0] count_o;
   logic       full_o;
   logic       empty_o;
   logic       almost_full_o;
   logic       almost_empty_o;
   logic       ovf_o;
   logic       udf_o;

   int tests = 0;
   int fails = 0;

   fifo_ctrl #(.DEPTH(8)) dut (
      .clk            (clk),
      .rst_i          (rst_i),
      .flush_i        (flush_i),
      .wr_en_i        (wr_en_i),
      .rd_en_i        (rd_en_i),
      .clr_err_i      (clr_err_i),
      .mem_we_o       (mem_we_o),
      .mem_waddr_o    (mem_waddr_o),
      .mem_re_o       (mem_re_o),
      .mem_raddr_o    (mem_raddr_o),
      .rd_valid_o     (rd_valid_o),
      .count_o        (count_o),
      .full_o         (full_o),
      .empty_o        (empty_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .ovf_o          (ovf_o),
      .udf_o          (udf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic wr, input logic rd, input logic fl,
                        input logic ce, input logic rs);
      wr_en_i   = wr;
      rd_en_i   = rd;
      flush_i   = fl;
      clr_err_i = ce;
      rst_i     = rs;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status(input string tag, input int cnt);
      chk({tag, "_count"}, count_o, cnt);
      chk({tag, "_full"}, full_o, cnt == 8);
      chk({tag, "_empty"}, empty_o, cnt == 0);
      chk({tag, "_af"}, almost_full_o, cnt >= 6);
      chk({tag, "_ae"}, almost_empty_o, cnt <= 2);
   endtask

   initial begin
      drive(1, 1, 0, 0, 1);
      chk("rst_we", mem_we_o, 0);
      chk("rst_re", mem_re_o, 0);
      tick();
      tick();
      chk_status("reset", 0);
      chk("reset_rdv", rd_valid_o, 0);
      chk("reset_ovf", ovf_o, 0);
      chk("reset_udf", udf_o, 0);

      // fill to full
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0, 0, 0);
         chk("fill_we", mem_we_o, 1);
         chk("fill_waddr", mem_waddr_o, i);
         tick();
         chk_status("fill", i + 1);
      end
      chk("fill_ovf", ovf_o, 0);

      // push while full
      drive(1, 0, 0, 0, 0);
      chk("ovf_we", mem_we_o, 0);
      tick();
      chk("ovf_count", count_o, 8);
      chk("ovf_set", ovf_o, 1);
      drive(0, 0, 0, 0, 0);
      tick();
      chk("ovf_sticky", ovf_o, 1);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("ovf_clr", ovf_o, 0);

      // drain to empty
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 0, 0, 0);
         chk("drain_re", mem_re_o, 1);
         chk("drain_raddr", mem_raddr_o, i);
         tick();
         chk("drain_rdv", rd_valid_o, 1);
         chk_status("drain", 7 - i);
      end
      drive(0, 1, 0, 0, 0);
      chk("udf_re", mem_re_o, 0);
      tick();
      chk("udf_set", udf_o, 1);
      chk("udf_rdv", rd_valid_o, 0);
      chk("udf_count", count_o, 0);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("udf_clr", udf_o, 0);

      // wrap from a fresh reset
      drive(0, 0, 0, 0, 1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 0);
         chk("w5_waddr", mem_waddr_o, i);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 0, 0);
         chk("r5_raddr", mem_raddr_o, i);
         tick();
      end
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, 0, 0);
         chk("wrap_we", mem_we_o, 1);
         chk("wrap_waddr", mem_waddr_o, (5 + i) % 8);
         tick();
      end
      chk_status("wrap", 6);

      // bring count to 3, then simultaneous push/pop
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0);
         tick();
      end
      chk("sim3_count0", count_o, 3);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 0, 0);
         chk("sim_we", mem_we_o, 1);
         chk("sim_re", mem_re_o, 1);
         chk("sim_waddr", mem_waddr_o, (3 + i) % 8);
         chk("sim_raddr", mem_raddr_o, i);
         tick();
         chk("sim_count", count_o, 3);
      end
      drive(0, 0, 0, 0, 0);
      chk("sim_waddr_end", mem_waddr_o, 7);
      chk("sim_raddr_end", mem_raddr_o, 4);

      // simultaneous at empty
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0);
         tick();
      end
      chk("e_empty", empty_o, 1);
      drive(1, 1, 0, 0, 0);
      chk("e_we", mem_we_o, 1);
      chk("e_re", mem_re_o, 0);
      tick();
      chk("e_count", count_o, 1);
      chk("e_udf", udf_o, 1);
      chk("e_ovf", ovf_o, 0);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("e_udf_clr", udf_o, 0);

      // simultaneous at full
      for (int i = 0; i < 7; i++) begin
         drive(1, 0, 0, 0, 0);
         tick();
      end
      chk("f_full", full_o, 1);
      drive(1, 1, 0, 0, 0);
      chk("f_we", mem_we_o, 0);
      chk("f_re", mem_re_o, 1);
      tick();
      chk_status("f", 7);
      chk("f_ovf", ovf_o, 1);
      chk("f_udf", udf_o, 0);

      // flush at count 5 with ovf held
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 0, 0);
         tick();
      end
      chk("fl_count0", count_o, 5);
      chk("fl_rdv0", rd_valid_o, 1);
      drive(1, 1, 1, 0, 0);
      chk("fl_we", mem_we_o, 0);
      chk("fl_re", mem_re_o, 0);
      tick();
      chk_status("flush", 0);
      chk("fl_rdv", rd_valid_o, 0);
      chk("fl_ovf", ovf_o, 1);
      chk("fl_udf", udf_o, 0);
      drive(0, 0, 0, 0, 1);
      tick();
      chk_status("rst2", 0);
      chk("rst2_ovf", ovf_o, 0);
      chk("rst2_waddr", mem_waddr_o, 0);
      chk("rst2_raddr", mem_raddr_o, 0);

      // reset drops an in-flight read
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 1, 0, 0, 1);
      chk("rmid_re", mem_re_o, 0);
      tick();
      chk("rmid_rdv", rd_valid_o, 0);
      chk("rmid_count", count_o, 0);
      drive(0, 0, 0, 0, 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
